// File: rtl/trigger_delay.sv
// Delays a trigger rising edge by a programmable number of target-clock rising
// edges, then emits a pulse lasting TRIG_CYCLES target-clock periods.
`timescale 1ns / 1ps

module trigger_delay #(
  parameter int unsigned TRIG_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        clean_target_clock,
  input  logic [31:0] delay,
  input  logic        set_delay,
  output logic        delayed_trigger
);

  localparam logic [1:0]  IDLE       = 2'd0;
  localparam logic [1:0]  WAIT       = 2'd1;
  localparam logic [1:0]  FIRE       = 2'd2;
  localparam logic [15:0] LAST_PULSE = 16'(TRIG_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] delay_reg_q, delay_reg_d;
  logic [31:0] remaining_q, remaining_d;
  logic [15:0] pulse_cnt_q, pulse_cnt_d;
  logic        trig_q;
  logic        tgt_q;
  logic        out_q;

  logic        trig_edge;
  logic        tgt_edge;

  // The target clock is treated as plain data; its rising edges are the time base.
  assign trig_edge = trigger & ~trig_q;
  assign tgt_edge  = clean_target_clock & ~tgt_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pulse_cnt_d = pulse_cnt_q;
    delay_reg_d = set_delay ? delay : delay_reg_q;

    // A running sequence keeps its own snapshot in remaining, so reloading
    // delay_reg mid-sequence only affects the next trigger.
    case (state_q)
      IDLE: begin
        if (trig_edge) begin
          pulse_cnt_d = '0;
          if (delay_reg_q == '0) begin
            state_d = FIRE;
          end else begin
            state_d     = WAIT;
            remaining_d = delay_reg_q;
          end
        end
      end
      WAIT: begin
        if (tgt_edge && (remaining_q != '0)) begin
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            state_d     = FIRE;
            pulse_cnt_d = '0;
          end
        end
      end
      FIRE: begin
        if (tgt_edge) begin
          pulse_cnt_d = pulse_cnt_q + 16'd1;
          if (pulse_cnt_q == LAST_PULSE) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      delay_reg_q <= '0;
      remaining_q <= '0;
      pulse_cnt_q <= '0;
      trig_q      <= 1'b0;
      tgt_q       <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_reg_q <= delay_reg_d;
      remaining_q <= remaining_d;
      pulse_cnt_q <= pulse_cnt_d;
      trig_q      <= trigger;
      tgt_q       <= clean_target_clock;
      out_q       <= (state_d == FIRE);
    end
  end

  assign delayed_trigger = out_q;

endmodule

// File: tb/tb_trigger_delay.sv
// Bench for trigger_delay: two instances (TRIG_CYCLES 1 and 3) share stimulus and
// are compared every cycle against an edge-counting reference model.
`timescale 1ns / 1ps

module tb_trigger_delay;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        clean_target_clock;
  logic [31:0] delay;
  logic        set_delay;
  logic        outT1;
  logic        outT3;

  trigger_delay #(.TRIG_CYCLES(1)) dutT1 (
    .clk                (clk),
    .rst                (rst),
    .trigger            (trigger),
    .clean_target_clock (clean_target_clock),
    .delay              (delay),
    .set_delay          (set_delay),
    .delayed_trigger    (outT1)
  );

  trigger_delay #(.TRIG_CYCLES(3)) dutT3 (
    .clk                (clk),
    .rst                (rst),
    .trigger            (trigger),
    .clean_target_clock (clean_target_clock),
    .delay              (delay),
    .set_delay          (set_delay),
    .delayed_trigger    (outT3)
  );

  always #1 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;

  // Model: a sequence accepted at cycle t with delay D covers target edges
  // E(t)+1 .. E(t)+D+T; output is high once E(t)+D edges have been seen.
  longint unsigned edgeCount  = 0;
  longint unsigned modelDelay = 0;
  logic            prevTrig   = 1'b0;
  logic            prevTgt    = 1'b0;
  bit              active[2]  = '{1'b0, 1'b0};
  longint unsigned baseEdge[2];
  longint unsigned seqDelay[2];
  longint unsigned pulseLen[2] = '{64'd1, 64'd3};
  bit              tgtRandom  = 1'b0;
  int              tgtLeft    = 2;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: delayed_trigger=%b, expected %b",
               tag, cycle, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic trigV, input logic setV,
                               input logic [31:0] dlyV);
    logic tgtEdge;
    logic trigEdge;
    logic expT1;
    logic expT3;
    @(negedge clk);
    cycle++;
    for (int i = 0; i < 2; i++) begin
      if (active[i] && (edgeCount >= baseEdge[i] + seqDelay[i] + pulseLen[i])) begin
        active[i] = 1'b0;
      end
    end
    expT1 = active[0] && (edgeCount >= baseEdge[0] + seqDelay[0]);
    expT3 = active[1] && (edgeCount >= baseEdge[1] + seqDelay[1]);
    checkOutput("pulseT1", outT1, expT1);
    checkOutput("pulseT3", outT3, expT3);

    if (tgtLeft == 0) begin
      clean_target_clock = ~clean_target_clock;
      tgtLeft = tgtRandom ? int'($urandom_range(1, 3)) : 2;
    end
    tgtLeft--;

    rst       = rstV;
    trigger   = trigV;
    set_delay = setV;
    delay     = dlyV;

    if (rstV) begin
      for (int i = 0; i < 2; i++) active[i] = 1'b0;
      modelDelay = 0;
      prevTrig   = 1'b0;
      prevTgt    = 1'b0;
    end else begin
      tgtEdge  = clean_target_clock & ~prevTgt;
      trigEdge = trigV & ~prevTrig;
      if (tgtEdge) edgeCount++;
      for (int i = 0; i < 2; i++) begin
        if (!active[i] && trigEdge) begin
          active[i]   = 1'b1;
          baseEdge[i] = edgeCount;
          seqDelay[i] = modelDelay;
        end
      end
      if (setV) modelDelay = longint'(dlyV);
      prevTrig = trigV;
      prevTgt  = clean_target_clock;
    end
  endtask

  task automatic runIdle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic loadDelay(input logic [31:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic pulseTrigger(input int len);
    for (int k = 0; k < len; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic rTrig;
    rst                = 1'b1;
    trigger            = 1'b0;
    clean_target_clock = 1'b0;
    delay              = 32'd0;
    set_delay          = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    runIdle(3);

    // Delay 6, two triggers 30 cycles apart
    loadDelay(32'd6);
    runIdle(2);
    pulseTrigger(4);
    runIdle(25);
    pulseTrigger(4);
    runIdle(50);

    // Delay 4
    loadDelay(32'd4);
    pulseTrigger(4);
    runIdle(40);

    // Delay 0 fires on the next cycle
    loadDelay(32'd0);
    pulseTrigger(2);
    runIdle(20);

    // Retrigger and reload during WAIT
    loadDelay(32'd6);
    pulseTrigger(2);
    runIdle(6);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    runIdle(50);
    pulseTrigger(2);
    runIdle(30);

    // Reset during WAIT, then during FIRE
    loadDelay(32'd5);
    pulseTrigger(2);
    runIdle(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    runIdle(40);
    loadDelay(32'd3);
    pulseTrigger(2);
    runIdle(14);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    runIdle(30);

    // Trigger held high through reset release
    loadDelay(32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    runIdle(30);

    // Random target period, triggers, reloads and resets
    tgtRandom = 1'b1;
    rTrig     = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) rTrig = ~rTrig;
      applyStimulus($urandom_range(0, 199) == 0, rTrig,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 8));
    end
    runIdle(4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/trigger_delay.md
TRIGGER_DELAY -- requirements
Module: trigger_delay

Interface
REQ-001 Parameter TRIG_CYCLES, default 1, width of the output pulse in target-clock periods; legal range 1..2^16-1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 trigger  input  1  trigger request; a 0->1 transition starts a delay sequence.
REQ-005 clean_target_clock  input  1  target clock, slower than clk, sampled as data in the clk domain; its rising edges are the time base.
REQ-006 delay  input  32  requested delay in target-clock rising edges, unsigned.
REQ-007 set_delay  input  1  level strobe; when high, delay is loaded into the internal delay register.
REQ-008 delayed_trigger  output  1  registered delayed pulse.

Function
REQ-009 Registers: delay_reg[31:0], trig_d, tgt_d (previous-cycle samples), remaining[31:0], pulse_cnt[15:0], state in {IDLE, WAIT, FIRE}.
REQ-010 trig_edge = trigger & ~trig_d; tgt_edge = clean_target_clock & ~tgt_d; both combinational on the current cycle's inputs; trig_d/tgt_d update every cycle.
REQ-011 Any cycle with set_delay=1 loads delay_reg <= delay, in any state; a sequence already in WAIT or FIRE is unaffected.
REQ-012 IDLE: on trig_edge, if delay_reg==0 go to FIRE with pulse_cnt=0, else go to WAIT with remaining=delay_reg (value before any same-cycle set_delay load).
REQ-013 WAIT: on tgt_edge, remaining decrements; when remaining==1 at that edge, go to FIRE with pulse_cnt=0.
REQ-014 FIRE: on tgt_edge, pulse_cnt increments; when pulse_cnt==TRIG_CYCLES-1 at that edge, go to IDLE.
REQ-015 delayed_trigger = 1 exactly in cycles where state==FIRE (registered, no combinational path from inputs).
REQ-016 Latency: delayed_trigger rises one clk cycle after the cycle detecting the delay_reg-th tgt_edge following trig_edge; width is exactly TRIG_CYCLES target periods (falls one clk cycle after the TRIG_CYCLES-th tgt_edge in FIRE).
REQ-017 delay_reg==0: delayed_trigger rises the clk cycle after trig_edge; first period is partial.
REQ-018 trig_edge in WAIT or FIRE is ignored (no retrigger, no queueing).
REQ-019 trig_edge and tgt_edge in the same IDLE cycle: that target edge is not counted.
REQ-020 Counters never wrap: remaining is only decremented while >=1; delay_reg up to 2^32-1 is legal.

Reset
REQ-021 While rst=1 at a clk edge: state=IDLE, delay_reg=0, remaining=0, pulse_cnt=0, trig_d=0, tgt_d=0, delayed_trigger=0; rst overrides set_delay and trigger.
REQ-022 rst mid-sequence (WAIT or FIRE) aborts it; delayed_trigger is 0 from the cycle after the reset edge.
REQ-023 A trigger held high through reset release counts as an edge only if it was low in the previous cycle (trig_d is 0 after reset, so it fires once).

Verification
(clk period 2 ns; clean_target_clock period 8 ns, i.e. 4 clk cycles.)
REQ-024 TRIG_CYCLES=1, set_delay loads delay 6, 8 ns trigger pulse -> delayed_trigger rises after the 6th target rising edge and stays high 4 clk cycles; second trigger 60 ns later repeats identically.
REQ-025 TRIG_CYCLES=3, delay 4 loaded -> delayed_trigger rises after the 4th target edge and stays high 12 clk cycles.
REQ-026 delay_reg=0, trigger edge -> delayed_trigger high the next clk cycle, falls after the TRIG_CYCLES-th target edge.
REQ-027 Delay 6 loaded; second trig_edge and set_delay with 2 applied during WAIT -> original sequence fires after edge 6, no second pulse; the next trigger uses delay 2.
REQ-028 rst asserted in WAIT and in FIRE -> delayed_trigger 0 next cycle, delay_reg 0, no later pulse without a new trigger.
